// File: rtl/mpmc10_pkg.sv
// mpmc10_pkg
//   Shared types and constants for the mpmc10 read-data collector:
//   the collector state enum, TRUE/FALSE, the default watchdog limit,
//   and the helper that clamps the requested last-strip index to the
//   line buffer size.
package mpmc10_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } rdc_state_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int unsigned MPMC10_RD_TIMEOUT_DEF = 255;

    // Requests for more strips than the line holds are truncated to a full line.
    function automatic logic [5:0] clamp_last(input logic [5:0] n,
                                              input logic [5:0] max_idx);
        return (n > max_idx) ? max_idx : n;
    endfunction

endpackage

// File: rtl/mpmc10_rd_watchdog.sv
// mpmc10_rd_watchdog
//   Idle-cycle watchdog for the read-data collector. While enabled, it
//   counts consecutive cycles without a kick. On the TIMEOUT-th such
//   cycle it raises timeout combinationally, so the owner can act on
//   that same edge. The count clears whenever enable is low or kick is high.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   enable    - count only while high (collector in COLLECT)
//   kick      - valid read beat; restarts the idle count
//   timeout   - high on the cycle that completes TIMEOUT idle cycles
module mpmc10_rd_watchdog
    import mpmc10_pkg::*;
#(
    parameter int unsigned TIMEOUT = MPMC10_RD_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic kick,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    assign timeout = enable && !kick && (count == CW'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || !enable || kick) begin
            count <= '0;
        end else if (!timeout) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mpmc10_rd_data_collect.sv
// mpmc10_rd_data_collect
//   Collects MIG read-return strips into a line buffer. A start latches
//   the requesting channel and the index of the last expected strip,
//   clamped to LINE_STRIPS-1. Each valid beat fills slot strip_cnt. The
//   beat that fills the last slot moves the FSM to DONE, which pulses
//   done for one cycle. Protocol violations set a sticky err:
//     - a beat with no burst open;
//     - a beat during DONE;
//     - a start while a burst is in flight.
// Configuration:
//   MPMC10_RD_TIMEOUT_EN - when defined, a watchdog aborts a COLLECT
//   that sees TIMEOUT cycles without a beat. The abort sets err and
//   returns to IDLE without done.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - read command accepted (latches num_strips, ch_i)
//   num_strips        - index of the last strip expected
//   ch_i              - requesting channel
//   app_rd_data_valid - MIG read beat valid
//   app_rd_data       - MIG read beat (one strip)
//   line_o            - assembled line, slot k at bits k*DATA_WIDTH
//   ch_o              - channel of the line
//   strip_cnt         - strips received in the current burst (saturates at 63)
//   busy              - FSM not in IDLE
//   done              - one-cycle pulse, line complete
//   err               - sticky protocol error, cleared only by rst
module mpmc10_rd_data_collect
    import mpmc10_pkg::*;
#(
    parameter int          DATA_WIDTH  = 128,
    parameter int          LINE_STRIPS = 4,
    parameter int unsigned TIMEOUT     = MPMC10_RD_TIMEOUT_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [5:0]                      num_strips,
    input  logic [3:0]                      ch_i,
    input  logic                            app_rd_data_valid,
    input  logic [DATA_WIDTH-1:0]           app_rd_data,
    output logic [DATA_WIDTH*LINE_STRIPS-1:0] line_o,
    output logic [3:0]                      ch_o,
    output logic [5:0]                      strip_cnt,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    localparam logic [5:0] LAST_MAX = 6'(LINE_STRIPS - 1);

    rdc_state_t state;
    logic [5:0] last;
    logic [5:0] start_last;
    logic       wd_timeout;

    assign start_last = clamp_last(num_strips, LAST_MAX);
    assign busy       = (state != IDLE);

`ifdef MPMC10_RD_TIMEOUT_EN
    mpmc10_rd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .enable  (state == COLLECT),
        .kick    (app_rd_data_valid),
        .timeout (wd_timeout)
    );
`else
    assign wd_timeout = FALSE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: line_o is a register bank, not a RAM, and it must read
            // zero after reset, so it is reset along with the control state.
            state     <= IDLE;
            last      <= '0;
            strip_cnt <= '0;
            ch_o      <= '0;
            line_o    <= '0;
            done      <= FALSE;
            err       <= FALSE;
        end else begin
            done <= FALSE;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= COLLECT;
                        last      <= start_last;
                        ch_o      <= ch_i;
                        strip_cnt <= '0;
                        // A beat coinciding with start is strip 0 of this burst.
                        if (app_rd_data_valid) begin
                            line_o[0 +: DATA_WIDTH] <= app_rd_data;
                            strip_cnt               <= 6'd1;
                            if (start_last == 6'd0) begin
                                state <= DONE;
                                done  <= TRUE;
                            end
                        end
                    end else if (app_rd_data_valid) begin
                        err <= TRUE;
                    end
                end

                COLLECT: begin
                    if (start) begin
                        err <= TRUE;
                    end
                    if (app_rd_data_valid) begin
                        // strip_cnt never exceeds last (at most LINE_STRIPS-1) here,
                        // so exactly one slot matches.
                        for (int s = 0; s < LINE_STRIPS; s++) begin
                            if (strip_cnt == 6'(s)) begin
                                line_o[s*DATA_WIDTH +: DATA_WIDTH] <= app_rd_data;
                            end
                        end
                        if (strip_cnt != 6'd63) begin
                            strip_cnt <= strip_cnt + 6'd1;
                        end
                        if (strip_cnt == last) begin
                            state <= DONE;
                            done  <= TRUE;
                        end
                    end else if (wd_timeout) begin
                        state <= IDLE;
                        err   <= TRUE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    if (start || app_rd_data_valid) begin
                        err <= TRUE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mpmc10_rd_data_collect.md
# mpmc10_rd_data_collect

Read-side counterpart to the write-data strip sequencer in the mpmc10 memory controller. Accepts MIG read-return beats (`app_rd_data_valid`/`app_rd_data`), counts strips against the requested strip count, and assembles them into a line buffer. When the last strip lands, it hands the completed line and requesting channel back to the controller state machine with a one-cycle `done` pulse. It sits between the MIG user interface read port and the per-channel read-response/cache-fill logic.

## Interface
- `DATA_WIDTH`, 128: MIG `app_rd_data` width (one strip).
- `LINE_STRIPS`, 4: strips per line buffer; line width is `DATA_WIDTH*LINE_STRIPS`.
- `TIMEOUT`, 255: watchdog limit in cycles; used only with the macro.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: read command accepted; latches `num_strips` and `ch_i`.
- `num_strips` in 6: index of the last strip expected; `num_strips+1` strips total.
- `ch_i` in 4: requesting channel.
- `app_rd_data_valid` in 1: MIG read beat valid.
- `app_rd_data` in DATA_WIDTH: MIG read beat.
- `line_o` out DATA_WIDTH*LINE_STRIPS: assembled line.
- `ch_o` out 4: channel of the completed line.
- `strip_cnt` out 6: strips received so far in the current burst.
- `busy` out 1: collecting.
- `done` out 1: one-cycle pulse when the line is complete.
- `err` out 1: sticky protocol-error flag, cleared only by reset.

## Operation
- States:
  - IDLE: on `start`, go to COLLECT. Latch `last = min(num_strips, LINE_STRIPS-1)`, latch `ch_i`, and set `strip_cnt` to 0.
  - COLLECT: each beat with `app_rd_data_valid` does two things at the same edge:
    - writes `app_rd_data` into `line_o` slot `strip_cnt` (bits `strip_cnt*DATA_WIDTH +: DATA_WIDTH`);
    - increments `strip_cnt`.
  - Beat with `strip_cnt==last`: go to DONE.
  - DONE: drive `done` for one cycle, then return to IDLE.
- A beat arriving in the same cycle as `start` while in IDLE is captured as strip 0. If that beat is also the last strip (`last==0`), go directly to DONE.
- Beat in IDLE without `start`, or beat in DONE: data dropped, `err` set.
- `start` while in COLLECT or DONE: ignored, `err` set.
- `strip_cnt` saturates at 63 and never wraps.
- `line_o` and `ch_o` hold their values until the next beat or `start`. Slots not written in the current burst keep stale data.
- `busy` = state != IDLE.

## Timing
- Reset values: state IDLE, `strip_cnt`=0, `busy`=0, `done`=0, `err`=0, `ch_o`=0, `line_o`=0.
- Latency: `done` is high on the cycle after the edge that captures the last beat. `line_o` is complete and stable while `done` is high.
- Minimum burst-to-burst spacing: one `done` cycle, then `start` is accepted in the next cycle (IDLE).
- Beats need not be contiguous; gaps of any length are allowed (unless the watchdog is enabled).
- `rst` asserted mid-burst: all registers return to reset values at the next edge. Partial data is discarded and no `done` is issued.
- `rst` has priority over all other inputs.

## Configuration
- `MPMC10_RD_TIMEOUT_EN` defined:
  - In COLLECT, a counter clears on every valid beat and increments otherwise.
  - On reaching `TIMEOUT`, `err` is set and the state goes to IDLE without `done`.
- `MPMC10_RD_TIMEOUT_EN` undefined: no counter. COLLECT waits indefinitely, and the `TIMEOUT` parameter is unused.

## Structure
- In `mpmc10_pkg`: the `rdc_state_t` enum (IDLE, COLLECT, DONE), TRUE/FALSE, and a `MPMC10_RD_TIMEOUT_DEF` constant used as the default for `TIMEOUT`.
- One sub-module: `mpmc10_rd_watchdog` (clk, rst, enable, kick, timeout pulse), instantiated only under `MPMC10_RD_TIMEOUT_EN`.

## Test plan
- Reset, then `start` with `num_strips`=3, `ch_i`=5, then 4 contiguous beats 0xA0..0xA3 -> `line_o`={A3,A2,A1,A0}, `ch_o`=5, `done` high for exactly 1 cycle, one cycle after the 4th beat; `err`=0.
- `num_strips`=1, beats separated by 10-cycle gaps -> `done` after the 2nd beat; `strip_cnt`=2; slots 2-3 unchanged from the previous burst.
- `start` and first beat in the same cycle, `num_strips`=0 -> slot 0 written, `done` on the next cycle.
- Beat with no outstanding `start`, plus a second `start` during COLLECT -> `err`=1; the in-flight burst still completes normally.
- `num_strips`=9 with `LINE_STRIPS`=4 -> clamped; `done` after 4 beats.
- With `MPMC10_RD_TIMEOUT_EN` and `TIMEOUT`=16, 2 of 4 beats then silence -> `err`=1 after 16 idle cycles, `busy`=0, no `done`. Separately, `rst` mid-burst -> all outputs return to 0.
